sync_fifo_gen: RTL

Parametrised synchronous FIFO, the successor to the keyboard/VGA 8×8 FIFO. Adds arbitrary power-of-two depth, selectable standard or first-word-fall-through (FWFT) read mode, a fill-level output, programmable almost-full and almost-empty flags, synchronous flush, and sticky overflow/underflow error flags. It is used wherever one clock domain buffers a byte or word stream, such as keyboard scan codes, UART characters or the text-write queue.

---
 rtl/sync_fifo_gen_pkg.sv | 17 +
 rtl/fifo_flopram.sv | 25 ++
 rtl/sync_fifo_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/sync_fifo_gen_pkg.sv
// rtl/sync_fifo_gen_pkg.sv - shared defaults and sizing helper for sync_fifo_gen
package sync_fifo_gen_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_flopram.sv
// rtl/fifo_flopram.sv - flop-based storage, synchronous write, combinational read
module fifo_flopram
  import sync_fifo_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [fifo_clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic [fifo_clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]               rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; pointers/level define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// rtl/sync_fifo_gen.sv - parametrised synchronous FIFO, standard or FWFT read
module sync_fifo_gen
  import sync_fifo_gen_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             inData,
  output logic                         notfull,
  input  logic                         pop,
  output logic [WIDTH-1:0]             outData,
  output logic                         notempty,
  output logic [fifo_clog2(DEPTH):0]   level,
  output logic                         almostFull,
  output logic                         almostEmpty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = fifo_clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

  logic [AW-1:0]    wptr, rptr;
  logic [LW-1:0]    level_nxt;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] rdata;

  // Registered flags make these exact for the current occupancy.
  assign wr_ok = push & notfull & ~flush;
  assign rd_ok = pop & notempty & ~flush;

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   level_nxt = level + LW'(1);
        2'b01:   level_nxt = level - LW'(1);
        default: level_nxt = level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      notfull     <= 1'b1;
      notempty    <= 1'b0;
      almostFull  <= (AF_THRESH == 0);
      almostEmpty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      level       <= level_nxt;
      notfull     <= (level_nxt != FULL_LVL);
      notempty    <= (level_nxt != '0);
      almostFull  <= (level_nxt >= AF_LVL);
      almostEmpty <= (level_nxt <= AE_LVL);
      if (flush) begin
        wptr      <= '0;
        rptr      <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_ok) wptr <= wptr + 1'b1;
        if (rd_ok) rptr <= rptr + 1'b1;
        if (push && !notfull) overflow  <= 1'b1;
        if (pop && !notempty) underflow <= 1'b1;
      end
    end
  end

  fifo_flopram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wptr),
    .wdata(inData),
    .raddr(rptr),
    .rdata(rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign outData = rdata;
    end else begin : g_std
      // Holds across flush and empty; only an accepted read reloads it.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    outData <= '0;
        else if (rd_ok) outData <= rdata;
      end
    end
  endgenerate

endmodule
